// File: rtl/sfft_readout_bridge_pkg.sv
// Shared constants, address-map helpers and decode types
// for the SFFT readout bridge.
package sfft_readout_pkg;

    localparam int ST_VALID   = 0;
    localparam int ST_LOCK    = 1;
    localparam int ST_OVR     = 2;

    localparam int CT_LOCK    = 0;
    localparam int CT_CLR_OVR = 1;

    typedef enum logic [1:0] {
        RG_BIN,
        RG_TS,
        RG_STAT,
        RG_NONE
    } region_e;

    function automatic int bin_bytes(input int n_bins, input int bin_w);
        return n_bins * (bin_w / 8);
    endfunction

    function automatic int status_addr(input int n_bins, input int bin_w,
                                       input int ts_w);
        return bin_bytes(n_bins, bin_w) + ts_w / 8;
    endfunction

endpackage

// File: rtl/sfft_readout_bridge_if.sv
// Bin capture stream plus byte-wide HPS bus of the readout bridge.
interface sfft_readout_bridge_if #(
    parameter int N_BINS = 256,
    parameter int BIN_W  = 32,
    parameter int ADDR_W = 16
);
    logic                      bin_valid;
    logic [$clog2(N_BINS)-1:0] bin_index;
    logic [BIN_W-1:0]          bin_data;
    logic                      frame_done;
    logic                      chipselect;
    logic                      read;
    logic                      write;
    logic [ADDR_W-1:0]         address;
    logic [7:0]                writedata;
    logic [7:0]                readdata;
    logic                      frame_ready;

    modport master (
        output bin_valid, bin_index, bin_data, frame_done,
        output chipselect, read, write, address, writedata,
        input  readdata, frame_ready
    );

    modport slave (
        input  bin_valid, bin_index, bin_data, frame_done,
        input  chipselect, read, write, address, writedata,
        output readdata, frame_ready
    );
endinterface

// File: rtl/sfft_readout_bridge_bank_ram.sv
// Simple dual-port bin store, bank select in the address MSB,
// registered read port so it maps onto block RAM.
module sfft_bank_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sfft_readout_bridge.sv
// Ping-pong capture of SFFT frames with timestamp, lock/pending/overrun
// control and a little-endian byte readout for the HPS driver.
module sfft_readout_bridge
    import sfft_readout_pkg::*;
#(
    parameter int N_BINS = 256,
    parameter int BIN_W  = 32,
    parameter int TS_W   = 32,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sfft_readout_bridge_if.slave bus
);
    localparam int IDX_W = $clog2(N_BINS);
    localparam int BB    = BIN_W / 8;
    localparam int OFF_W = (BB > 1) ? $clog2(BB) : 1;
    localparam int TSB   = TS_W / 8;
    localparam logic [ADDR_W-1:0] A_TS = ADDR_W'(bin_bytes(N_BINS, BIN_W));
    localparam logic [ADDR_W-1:0] A_ST =
        ADDR_W'(status_addr(N_BINS, BIN_W, TS_W));
    localparam logic [ADDR_W-1:0] BB_A = ADDR_W'(BB);

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 valid_q, valid_d;
    logic                 lock_q, lock_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_ready_q, frame_ready_d;
    logic [TS_W-1:0]      cnt_q, cnt_d;
    logic [1:0][TS_W-1:0] ts_q, ts_d;
    logic                 is_bin_q, is_bin_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic [7:0]           other_q, other_d;

    region_e           region;
    logic              rd_req;
    logic              ctl_wr;
    logic              lock_nx;
    logic              fd_locked;
    logic              swap;
    logic [ADDR_W-1:0] ts_off;
    logic [TS_W-1:0]   ts_rd;
    logic [7:0]        ts_byte;
    logic [7:0]        st_byte;
    logic [7:0]        imm_byte;
    logic [7:0]        bin_byte;
    logic              ram_re;
    logic [IDX_W:0]    ram_waddr;
    logic [IDX_W:0]    ram_raddr;
    logic [BIN_W-1:0]  ram_rdata;

    always_comb begin
        region = RG_NONE;
        if (bus.address < A_TS) begin
            region = RG_BIN;
        end else if (bus.address < A_ST) begin
            region = RG_TS;
        end else if (bus.address == A_ST) begin
            region = RG_STAT;
        end
    end

    assign rd_req = bus.chipselect & bus.read;
    assign ctl_wr = bus.chipselect & bus.write & (region == RG_STAT);

    // A lock written in the same cycle as frame_done already applies to it.
    assign lock_nx   = ctl_wr ? bus.writedata[CT_LOCK] : lock_q;
    assign fd_locked = bus.frame_done & lock_nx;
    assign swap      = (bus.frame_done & ~lock_nx)
                     | (lock_q & ~lock_nx & pending_q);

    always_comb begin
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        valid_d       = valid_q;
        lock_d        = lock_nx;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        cnt_d         = cnt_q;
        ts_d          = ts_q;
        frame_ready_d = swap;

        if (bus.frame_done) begin
            cnt_d            = cnt_q + TS_W'(1);
            ts_d[wr_bank_q]  = cnt_q;
        end
        if (fd_locked) begin
            pending_d = 1'b1;
        end
        if (ctl_wr & bus.writedata[CT_CLR_OVR]) begin
            overrun_d = 1'b0;
        end
        if (fd_locked & pending_q) begin
            overrun_d = 1'b1;
        end
        if (swap) begin
            wr_bank_d = rd_bank_q;
            rd_bank_d = wr_bank_q;
            valid_d   = 1'b1;
            pending_d = 1'b0;
        end
    end

    assign ts_off = bus.address - A_TS;
    assign ts_rd  = ts_q[rd_bank_q];

    always_comb begin
        ts_byte = '0;
        for (int i = 0; i < TSB; i++) begin
            if (ts_off == ADDR_W'(i)) begin
                ts_byte = ts_rd[8*i +: 8];
            end
        end
    end

    always_comb begin
        st_byte           = '0;
        st_byte[ST_VALID] = valid_q;
        st_byte[ST_LOCK]  = lock_q;
        st_byte[ST_OVR]   = overrun_q;
    end

    always_comb begin
        unique case (region)
            RG_TS:   imm_byte = ts_byte;
            RG_STAT: imm_byte = st_byte;
            default: imm_byte = '0;
        endcase
    end

    // Bin bytes come from the RAM's own output register; everything
    // else is latched here so both paths return on the same cycle.
    always_comb begin
        is_bin_d = is_bin_q;
        off_d    = off_q;
        other_d  = other_q;
        if (rd_req) begin
            is_bin_d = (region == RG_BIN) & valid_q;
            off_d    = OFF_W'(bus.address % BB_A);
            other_d  = imm_byte;
        end
    end

    assign ram_re    = rd_req & (region == RG_BIN);
    assign ram_waddr = {wr_bank_q, bus.bin_index};
    assign ram_raddr = {rd_bank_q, IDX_W'(bus.address / BB_A)};

    sfft_bank_ram #(
        .DEPTH (2 * N_BINS),
        .AW    (IDX_W + 1),
        .WIDTH (BIN_W)
    ) u_ram (
        .clk   (clk),
        .we    (bus.bin_valid),
        .waddr (ram_waddr),
        .wdata (bus.bin_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        bin_byte = '0;
        for (int i = 0; i < BB; i++) begin
            if (off_q == OFF_W'(i)) begin
                bin_byte = ram_rdata[8*i +: 8];
            end
        end
    end

    assign bus.readdata    = is_bin_q ? bin_byte : other_q;
    assign bus.frame_ready = frame_ready_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            valid_q       <= 1'b0;
            lock_q        <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            cnt_q         <= '0;
            ts_q          <= '0;
            is_bin_q      <= 1'b0;
            off_q         <= '0;
            other_q       <= '0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            valid_q       <= valid_d;
            lock_q        <= lock_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_ready_q <= frame_ready_d;
            cnt_q         <= cnt_d;
            ts_q          <= ts_d;
            is_bin_q      <= is_bin_d;
            off_q         <= off_d;
            other_q       <= other_d;
        end
    end

endmodule

// File: tb/tb_sfft_readout_bridge.sv
// Bench: two bridges (TS_W=32 and TS_W=8) driven in lockstep and
// checked against a frame-level model plus literal expectations.
module tb_sfft_readout_bridge;
    localparam int NB = 8;
    localparam int BW = 32;
    localparam int AW = 16;
    localparam int S  = 36;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic          bv = 1'b0, fd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    wd = '0;
    logic [2:0]    bi = '0;
    logic [31:0]   bd = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_bank [2][NB];
    logic [31:0] m_ts [2];
    logic [31:0] m_cnt;
    int          m_wb;
    bit          m_valid, m_lock, m_pend, m_ovr;
    logic [7:0]  exp_a = '0, exp_b = '0;
    bit          exp_fr = 1'b0;

    sfft_readout_bridge_if #(.N_BINS(NB), .BIN_W(BW), .ADDR_W(AW)) ia ();
    sfft_readout_bridge_if #(.N_BINS(NB), .BIN_W(BW), .ADDR_W(AW)) ib ();

    // The TS_W=8 part has a 1-byte timestamp, so its status sits at 33;
    // logical addresses here follow the TS_W=32 map.
    function automatic logic [AW-1:0] map_b(input logic [AW-1:0] a);
        if (a == AW'(S)) return AW'(33);
        if (a >= AW'(33) && a <= AW'(35)) return AW'(40);
        return a;
    endfunction

    assign ia.bin_valid  = bv;  assign ib.bin_valid  = bv;
    assign ia.bin_index  = bi;  assign ib.bin_index  = bi;
    assign ia.bin_data   = bd;  assign ib.bin_data   = bd;
    assign ia.frame_done = fd;  assign ib.frame_done = fd;
    assign ia.chipselect = cs;  assign ib.chipselect = cs;
    assign ia.read       = rd;  assign ib.read       = rd;
    assign ia.write      = wr;  assign ib.write      = wr;
    assign ia.writedata  = wd;  assign ib.writedata  = wd;
    assign ia.address    = addr;
    assign ib.address    = map_b(addr);

    sfft_readout_bridge #(.N_BINS(NB), .BIN_W(BW), .TS_W(32), .ADDR_W(AW))
        dut_a (.clk(clk), .reset(rst_n), .bus(ia));
    sfft_readout_bridge #(.N_BINS(NB), .BIN_W(BW), .TS_W(8), .ADDR_W(AW))
        dut_b (.clk(clk), .reset(rst_n), .bus(ib));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] m_byte(input int a, input int tsw);
        logic [31:0] w;
        if (a < 32) begin
            if (!m_valid) return 8'h00;
            w = m_bank[m_wb ^ 1][a / 4];
            return w[8*(a % 4) +: 8];
        end
        if (a < 36) begin
            if (a - 32 >= tsw / 8) return 8'h00;
            w = m_ts[m_wb ^ 1];
            return w[8*(a - 32) +: 8];
        end
        if (a == S) return {5'b0, m_ovr, m_lock, m_valid};
        return 8'h00;
    endfunction

    task automatic model_step();
        bit ctl, lock_n, swap;
        if (!rst_n) begin
            m_wb = 0; m_ts[0] = 0; m_ts[1] = 0; m_cnt = 0;
            m_valid = 0; m_lock = 0; m_pend = 0; m_ovr = 0;
            exp_a = 0; exp_b = 0; exp_fr = 0;
            return;
        end
        if (cs && rd) begin
            exp_a = m_byte(int'(addr), 32);
            exp_b = m_byte(int'(addr), 8);
        end
        ctl    = cs && wr && (addr == AW'(S));
        lock_n = ctl ? wd[0] : m_lock;
        swap   = 0;
        if (bv) m_bank[m_wb][bi] = bd;
        if (ctl && wd[1]) m_ovr = 0;
        if (fd) begin
            m_ts[m_wb] = m_cnt;
            m_cnt++;
            if (lock_n) begin
                if (m_pend) m_ovr = 1;
                m_pend = 1;
            end else begin
                swap = 1;
            end
        end
        if (m_lock && !lock_n && m_pend) swap = 1;
        if (swap) begin
            m_wb ^= 1; m_valid = 1; m_pend = 0;
        end
        m_lock = lock_n;
        exp_fr = swap;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("readdata_a", 32'(ia.readdata), 32'(exp_a));
        chk("readdata_b", 32'(ib.readdata), 32'(exp_b));
        chk("frame_ready_a", 32'(ia.frame_ready), 32'(exp_fr));
        chk("frame_ready_b", 32'(ib.frame_ready), 32'(exp_fr));
    end

    task automatic idle();
        cs = 0; rd = 0; wr = 0; bv = 0; fd = 0;
    endtask

    task automatic rdchk(input string nm, input int a,
                         input logic [7:0] ea, input logic [7:0] eb);
        cs = 1; rd = 1; addr = AW'(a);
        @(negedge clk);
        idle();
        chk({nm, "_a"}, 32'(ia.readdata), 32'(ea));
        chk({nm, "_b"}, 32'(ib.readdata), 32'(eb));
    endtask

    task automatic wrc(input int a, input logic [7:0] d);
        cs = 1; wr = 1; addr = AW'(a); wd = d;
        @(negedge clk);
        idle();
    endtask

    // Bins go out in a scrambled order; ctl >= 0 writes S alongside frame_done.
    task automatic frame(input logic [31:0] base, input int nb,
                         input bit merge, input int ctl);
        for (int k = 0; k < nb; k++) begin
            bv = 1; bi = 3'((k * 3) % 8); bd = base + 32'((k * 3) % 8);
            if (merge && k == nb - 1) begin
                fd = 1;
                if (ctl >= 0) begin
                    cs = 1; wr = 1; addr = AW'(S); wd = 8'(ctl);
                end
            end
            @(negedge clk);
            idle();
        end
        if (!merge) begin
            fd = 1;
            if (ctl >= 0) begin
                cs = 1; wr = 1; addr = AW'(S); wd = 8'(ctl);
            end
            @(negedge clk);
            idle();
        end
    endtask

    initial begin
        logic [7:0] eb4 [4];
        eb4[0] = 8'hD1; eb4[1] = 8'hC2; eb4[2] = 8'hB1; eb4[3] = 8'hA0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        rdchk("st_reset", S, 8'h00, 8'h00);
        rdchk("bin_reset", 0, 8'h00, 8'h00);

        frame(32'hA0B1C2D0, 8, 0, -1);
        chk("ready_first", 32'(ia.frame_ready), 1);
        rdchk("st_valid", S, 8'h01, 8'h01);
        for (int i = 0; i < 4; i++) rdchk("bin1_le", 4 + i, eb4[i], eb4[i]);
        for (int i = 0; i < 4; i++) rdchk("ts_first", 32 + i, 8'h00, 8'h00);

        wrc(S, 8'h01);
        frame(32'h11110000, 8, 0, -1);
        frame(32'h22220000, 8, 1, -1);
        frame(32'h33330000, 8, 0, -1);
        chk("no_ready_locked", 32'(ia.frame_ready), 0);
        rdchk("bin_locked", 4, 8'hD1, 8'hD1);
        rdchk("st_overrun", S, 8'h07, 8'h07);
        wrc(S, 8'h03);
        rdchk("st_ovr_clr", S, 8'h03, 8'h03);
        wrc(S, 8'h00);
        chk("ready_unlock", 32'(ia.frame_ready), 1);
        rdchk("ts_three", 32, 8'h03, 8'h03);
        rdchk("bin_after_unlock", 4, 8'h01, 8'h01);

        frame(32'h44440000, 8, 0, 1);
        chk("no_ready_same_lock", 32'(ia.frame_ready), 0);
        rdchk("st_pending", S, 8'h03, 8'h03);
        rdchk("ts_held", 32, 8'h03, 8'h03);
        wrc(S, 8'h00);
        chk("ready_pending", 32'(ia.frame_ready), 1);
        rdchk("ts_four", 32, 8'h04, 8'h04);
        rdchk("bin_four", 2, 8'h44, 8'h44);

        wrc(S, 8'h01);
        frame(32'h55550000, 8, 0, -1);
        frame(32'h66660000, 8, 1, 0);
        chk("ready_unlock_fd", 32'(ia.frame_ready), 1);
        rdchk("st_unlock_fd", S, 8'h01, 8'h01);
        rdchk("ts_six", 32, 8'h06, 8'h06);
        rdchk("bin_six", 20, 8'h05, 8'h05);

        wrc(0, 8'h01);
        rdchk("st_bad_wr", S, 8'h01, 8'h01);

        wrc(S, 8'h01);
        frame(32'h77770000, 8, 0, -1);
        frame(32'h88880000, 8, 0, 3);
        rdchk("st_ovr_wins", S, 8'h07, 8'h07);
        wrc(S, 8'h03);
        rdchk("st_ovr_clr2", S, 8'h03, 8'h03);
        wrc(S, 8'h00);
        chk("ready_ovr", 32'(ia.frame_ready), 1);
        rdchk("ts_eight", 32, 8'h08, 8'h08);
        rdchk("unmapped", 50, 8'h00, 8'h00);

        for (int f = 9; f < 256; f++) frame(32'(f) << 8, 1, 1, -1);
        frame(32'hDEAD0000, 8, 0, -1);
        rdchk("ts_wrap_lo", 32, 8'h00, 8'h00);
        rdchk("ts_wrap_hi", 33, 8'h01, 8'h00);
        rdchk("bin_wrap", 8, 8'h02, 8'h02);
        rdchk("bin_wrap_msb", 11, 8'hDE, 8'hDE);

        wrc(S, 8'h01);
        for (int k = 0; k < 3; k++) begin
            bv = 1; bi = 3'(k); bd = 32'hBAD00000 + 32'(k);
            @(negedge clk);
            idle();
        end
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        rdchk("st_mid_reset", S, 8'h00, 8'h00);
        rdchk("bin_mid_reset", 0, 8'h00, 8'h00);
        frame(32'hF00D0000, 8, 0, -1);
        chk("ready_post_reset", 32'(ia.frame_ready), 1);
        rdchk("st_post_reset", S, 8'h01, 8'h01);
        rdchk("ts_post_reset", 32, 8'h00, 8'h00);
        rdchk("bin_post_reset", 3, 8'hF0, 8'hF0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
